uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART TX FIFO push interface between NUM_SRC independent byte-stream requesters (status reporter, debug echo, plotter ack, ...).
- Grants the FIFO to one requester for a whole packet (start to `last`), round-robin between packets.
- Optionally prefixes each packet with a source-ID header byte.
- Sits directly in front of the TX FIFO's `tx_data`/`push`/`tx_fifo_full` interface.

Parameters:
- NUM_SRC, 3, number of requesters (2..8).
- DATA_WIDTH, 8, byte width of payload and header.
- HDR_EN, 1, 1 = emit header byte before payload; 0 = payload only.
- HDR_BASE, 8'hA0, header value = HDR_BASE + source index (modulo 2^DATA_WIDTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte valid; high also means "request".
- src_data  in  NUM_SRC*DATA_WIDTH  per-source byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_last  in  NUM_SRC  per-source marker: current byte ends the packet.
- src_ready  out  NUM_SRC  per-source byte accepted this cycle (one-hot or zero).
- tx_data  out  DATA_WIDTH  byte to FIFO.
- push  out  1  FIFO write strobe, one byte per high cycle.
- tx_fifo_full  in  1  FIFO full flag.
- grant  out  $clog2(NUM_SRC)  index of the current/last owner.
- busy  out  1  high while a packet is in progress (state != IDLE).

Behaviour:
- FSM states: IDLE, HDR, PAYLOAD.
  - IDLE: if any src_valid, pick winner round-robin, starting at (last_grant+1) mod NUM_SRC. Register grant; go to HDR if HDR_EN, else PAYLOAD. Arbitration takes exactly one cycle; no push in IDLE.
  - HDR: tx_data = HDR_BASE + grant. push = !tx_fifo_full. When push fires, go to PAYLOAD. Holds while full.
  - PAYLOAD: tx_data = src_data[grant]. push = src_ready[grant] = src_valid[grant] & !tx_fifo_full. Transfer occurs when push=1. A transfer with src_last[grant]=1 goes to IDLE and updates last_grant = grant.
- push, src_ready and tx_data are combinational from registered state, grant, tx_fifo_full and src inputs. No other outputs depend combinationally on inputs.
- Payload byte latency: the byte is presented to the FIFO in the same cycle it is accepted.
- Non-granted src_ready are always 0. Sources hold valid/data/last stable until ready (AXI-stream-like rule).
- src_valid low mid-packet: stall in PAYLOAD, no push, grant retained indefinitely (no timeout).
- tx_fifo_full high: no push and no ready in any state. Resume on the first cycle full is low.
- Single-byte packet (last on first byte): legal. HDR_EN=1 gives header plus one byte.
- Back-to-back: after a last transfer, one IDLE cycle always precedes the next grant, including for the same source.
- Simultaneous requests: round-robin guarantees each waiting source is served within NUM_SRC packets.
- Reset (async, any time): state=IDLE, grant=0, last_grant=NUM_SRC-1 (source 0 wins first), busy=0, push=0, src_ready=0. tx_data=0 while IDLE. A partial packet is abandoned, with no further pushes.
- Header arithmetic truncates to DATA_WIDTH bits.

Test Plan:
- Single source: src0 sends 0x11,0x22,0x33 (last on 0x33), HDR_EN=1, FIFO never full -> pushes A0,11,22,33 on 4 consecutive cycles after 1 IDLE cycle; busy drops the cycle after 0x33.
- Contention: src0/src1/src2 each hold a 2-byte packet from cycle 0 -> packet order 0,1,2, headers A0,A1,A2. Then src0 again with src2 waiting -> src2 served before src0 (RR from last_grant=0 → src1 idle, picks 2).
- Backpressure: tx_fifo_full high for 5 cycles during payload byte 2 of 4 -> no push or ready for 5 cycles; byte 2 pushed the cycle full falls; no duplicates or drops.
- Source stall: src1 drops valid for 3 cycles mid-packet while src0 requests -> grant stays 1, src0 ready stays 0 until src1 last.
- Single-byte packets back-to-back from src2, HDR_EN=0 -> push pattern 1,0,1,0 (IDLE gap each packet).
- Reset asserted mid-payload (asynchronously, between clock edges) -> push and src_ready go 0 immediately, busy=0. After release, a src1 request gets header A1 and grant=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO push port
// between several byte-stream sources, with an optional source-ID header.
module uart_tx_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_WIDTH = 8,
    parameter bit HDR_EN = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE = 8'hA0,
    localparam int GW = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          push,
    input  logic                          tx_fifo_full,
    output logic [GW-1:0]                 grant,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t state, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] winner;
    logic found;
    logic [DATA_WIDTH-1:0] sel_data;
    logic sel_valid;
    logic sel_last;
    logic [DATA_WIDTH-1:0] hdr_byte;

    // Search starts one past the previous owner so every waiter is reached.
    always_comb begin
        int idx_i;
        logic [GW-1:0] idx;
        winner = last_grant_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx_i = (int'(last_grant_q) + k) % NUM_SRC;
            idx = GW'(idx_i);
            if (!found && src_valid[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_valid = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = src_valid[i];
                sel_last = src_last[i];
            end
        end
    end

    assign hdr_byte = HDR_BASE + DATA_WIDTH'(grant_q);

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        last_grant_d = last_grant_q;
        push = 1'b0;
        tx_data = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = HDR_EN ? HDR : PAYLOAD;
                end
            end
            HDR: begin
                tx_data = hdr_byte;
                push = !tx_fifo_full;
                if (push) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                tx_data = sel_data;
                push = sel_valid && !tx_fifo_full;
                if (push && sel_last) begin
                    state_d = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (state == PAYLOAD) && push
                           && (grant_q == GW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant_q <= '0;
            last_grant_q <= GW'(NUM_SRC - 1);
        end else begin
            state <= state_d;
            grant_q <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with header bytes,
// a second with headers disabled.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] src_valid, src_last;
    logic [23:0] src_data;
    logic tx_fifo_full;
    logic [2:0] src_ready;
    logic [7:0] tx_data;
    logic push, busy;
    logic [1:0] grant;

    logic [2:0] b_valid, b_last, b_ready;
    logic [23:0] b_data;
    logic [7:0] b_tx;
    logic b_push, b_busy;
    logic [1:0] b_grant;

    uart_tx_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .HDR_EN(1'b1),
                      .HDR_BASE(8'hA0)) u_dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .tx_data(tx_data), .push(push),
        .tx_fifo_full(tx_fifo_full), .grant(grant), .busy(busy)
    );

    uart_tx_arbiter #(.NUM_SRC(3), .DATA_WIDTH(8), .HDR_EN(1'b0),
                      .HDR_BASE(8'hA0)) u_dut_nohdr (
        .clk(clk), .reset(reset),
        .src_valid(b_valid), .src_data(b_data), .src_last(b_last),
        .src_ready(b_ready), .tx_data(b_tx), .push(b_push),
        .tx_fifo_full(1'b0), .grant(b_grant), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int viol = 0;

    // Source queues: bit 8 = last flag, bits 7:0 = byte.
    logic [8:0] sq0[$];
    logic [8:0] sq1[$];
    logic [8:0] sq2[$];
    logic [2:0] hold = 3'b000;
    logic full = 1'b0;
    logic [2:0] bv = 3'b000, bl = 3'b000;
    logic [23:0] bd = 24'h0;

    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];
    logic s_push, s_busy, sb_push;
    logic [7:0] s_data, sb_data;
    logic [2:0] s_ready, sb_ready;
    logic [1:0] s_grant, sb_grant;

    task automatic drive();
        src_valid[0] = (sq0.size() != 0) && !hold[0];
        src_data[7:0] = (sq0.size() != 0) ? sq0[0][7:0] : 8'h00;
        src_last[0] = (sq0.size() != 0) && sq0[0][8];
        src_valid[1] = (sq1.size() != 0) && !hold[1];
        src_data[15:8] = (sq1.size() != 0) ? sq1[0][7:0] : 8'h00;
        src_last[1] = (sq1.size() != 0) && sq1[0][8];
        src_valid[2] = (sq2.size() != 0) && !hold[2];
        src_data[23:16] = (sq2.size() != 0) ? sq2[0][7:0] : 8'h00;
        src_last[2] = (sq2.size() != 0) && sq2[0][8];
        tx_fifo_full = full;
        b_valid = bv;
        b_data = bd;
        b_last = bl;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #4;
        s_push = push;
        s_data = tx_data;
        s_ready = src_ready;
        s_busy = busy;
        s_grant = grant;
        sb_push = b_push;
        sb_data = b_tx;
        sb_ready = b_ready;
        sb_grant = b_grant;
        if (push) log_q.push_back(tx_data);
        if ((src_ready & (src_ready - 3'd1)) != 3'd0) viol++;
        if (src_ready != 3'd0 && src_ready[grant] !== 1'b1) viol++;
        if (src_ready[0]) void'(sq0.pop_front());
        if (src_ready[1]) void'(sq1.pop_front());
        if (src_ready[2]) void'(sq2.pop_front());
    endtask

    task automatic test_reset();
        drive();
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_cmp++;
        if (push !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_push got %b want 0", push);
        end
        n_cmp++;
        if (src_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 000", src_ready);
        end
        n_cmp++;
        if (grant !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant got %0d want 0", grant);
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data got %h want 00", tx_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [5:0] exp_push;
        exp_push = 6'b011110;
        log_q.delete();
        sq0.push_back(9'h011);
        sq0.push_back(9'h022);
        sq0.push_back(9'h133);
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (s_push !== exp_push[5-i]) begin
                n_fail++;
                $display("FAIL single_push[%0d] got %b want %b",
                         i, s_push, exp_push[5-i]);
            end
            if (i == 4) begin
                n_cmp++;
                if (s_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy_last got %b want 1", s_busy);
                end
            end
        end
        n_cmp++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after got %b want 0", s_busy);
        end
        exp_q = '{8'hA0, 8'h11, 8'h22, 8'h33};
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count got %0d want %0d",
                     log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL single_byte[%0d] got %h want %h",
                             i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        viol = 0;
        sq0.push_back(9'h001);
        sq0.push_back(9'h102);
        sq1.push_back(9'h003);
        sq1.push_back(9'h104);
        sq2.push_back(9'h005);
        sq2.push_back(9'h106);
        for (int i = 0; i < 13; i++) step();
        sq0.push_back(9'h109);
        for (int i = 0; i < 4; i++) step();
        sq0.push_back(9'h10A);
        sq2.push_back(9'h10B);
        for (int i = 0; i < 7; i++) step();
        exp_q = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'h04,
                  8'hA2, 8'h05, 8'h06, 8'hA0, 8'h09,
                  8'hA2, 8'h0B, 8'hA0, 8'h0A};
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rr_count got %0d want %0d",
                     log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rr_byte[%0d] got %h want %h",
                             i, log_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL ready_onehot got %0d bad cycles want 0", viol);
        end
    endtask

    task automatic test_backpressure();
        log_q.delete();
        sq1.push_back(9'h021);
        sq1.push_back(9'h022);
        sq1.push_back(9'h023);
        sq1.push_back(9'h124);
        for (int i = 0; i < 3; i++) step();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (s_push !== 1'b0 || s_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL full_hold[%0d] got push=%b ready=%b want 0/000",
                         i, s_push, s_ready);
            end
        end
        full = 1'b0;
        step();
        n_cmp++;
        if (s_push !== 1'b1 || s_data !== 8'h22) begin
            n_fail++;
            $display("FAIL full_resume got push=%b data=%h want 1/22",
                     s_push, s_data);
        end
        for (int i = 0; i < 3; i++) step();
        exp_q = '{8'hA1, 8'h21, 8'h22, 8'h23, 8'h24};
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count got %0d want %0d",
                     log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_byte[%0d] got %h want %h",
                             i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        log_q.delete();
        sq1.push_back(9'h031);
        sq1.push_back(9'h032);
        sq1.push_back(9'h133);
        step();
        sq0.push_back(9'h141);
        step();
        step();
        hold[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (s_push !== 1'b0 || s_ready !== 3'b000
                || s_grant !== 2'd1 || s_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall[%0d] got push=%b ready=%b grant=%0d busy=%b want 0/000/1/1",
                         i, s_push, s_ready, s_grant, s_busy);
            end
        end
        hold[1] = 1'b0;
        step();
        n_cmp++;
        if (s_push !== 1'b1 || s_data !== 8'h32) begin
            n_fail++;
            $display("FAIL stall_resume got push=%b data=%h want 1/32",
                     s_push, s_data);
        end
        for (int i = 0; i < 5; i++) step();
        exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'hA0, 8'h41};
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count got %0d want %0d",
                     log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL stall_byte[%0d] got %h want %h",
                             i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_push;
        exp_push = 5'b01010;
        bv = 3'b100;
        bl = 3'b100;
        for (int i = 0; i < 5; i++) begin
            bd = (i < 2) ? 24'h510000 : 24'h520000;
            if (i == 4) bv = 3'b000;
            step();
            n_cmp++;
            if (sb_push !== exp_push[4-i]) begin
                n_fail++;
                $display("FAIL b2b_push[%0d] got %b want %b",
                         i, sb_push, exp_push[4-i]);
            end
            if (i == 1 || i == 3) begin
                n_cmp++;
                if (sb_data !== ((i == 1) ? 8'h51 : 8'h52)
                    || sb_ready !== 3'b100 || sb_grant !== 2'd2) begin
                    n_fail++;
                    $display("FAIL b2b_xfer[%0d] got data=%h ready=%b grant=%0d",
                             i, sb_data, sb_ready, sb_grant);
                end
            end
        end
        bl = 3'b000;
        bd = 24'h0;
    endtask

    task automatic test_reset_mid();
        log_q.delete();
        sq0.push_back(9'h061);
        sq0.push_back(9'h062);
        sq0.push_back(9'h063);
        sq0.push_back(9'h164);
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        drive();
        #2;
        n_cmp++;
        if (push !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_push got %b want 1", push);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (push !== 1'b0 || src_ready !== 3'b000 || busy !== 1'b0
            || grant !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset got push=%b ready=%b busy=%b grant=%0d want 0/000/0/0",
                     push, src_ready, busy, grant);
        end
        sq0.delete();
        step();
        n_cmp++;
        if (s_push !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_push got %b want 0", s_push);
        end
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        sq1.push_back(9'h171);
        step();
        step();
        n_cmp++;
        if (s_push !== 1'b1 || s_data !== 8'hA1 || s_grant !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_hdr got push=%b data=%h grant=%0d want 1/a1/1",
                     s_push, s_data, s_grant);
        end
        step();
        step();
        exp_q = '{8'hA1, 8'h71};
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL post_reset_count got %0d want %0d",
                     log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (log_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL post_reset_byte[%0d] got %h want %h",
                             i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
